// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares one variable-latency req/ack memory port between the
//            instruction-fetch side (I) and the memory-stage side (D).
//            D has priority over I. A starvation counter forces an I grant
//            after STARVE_LIMIT consecutive D grants while I is waiting.
//            Flush cancels the delivery of an in-flight fetch. The memory
//            transaction itself still runs to completion.
// Ports    : CLK, RESET         clock, asynchronous active-high reset
//            I_Req/I_Addr       fetch request (level) and address
//            I_Data/I_Valid     fetched word with a one-cycle valid pulse
//            D_Req/D_Write/D_Addr/D_WData  data request (level)
//            D_RData/D_Valid    load data with a one-cycle valid pulse
//            Flush              fetch redirect
//            Mem_Req/Mem_Write/Mem_Addr/Mem_WData  registered memory request
//            Mem_Ack/Mem_RData  one-cycle completion and read data
// Revision : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int STARVE_LIMIT = 4      // 1..7
) (
    input  logic        CLK,
    input  logic        RESET,
    // fetch side
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    output logic [31:0] I_Data,
    output logic        I_Valid,
    // data side
    input  logic        D_Req,
    input  logic        D_Write,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_WData,
    output logic [31:0] D_RData,
    output logic        D_Valid,
    // redirect
    input  logic        Flush,
    // memory port
    output logic        Mem_Req,
    output logic        Mem_Write,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData
);

    localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_drop;
    logic [2:0]  r_starve;

    logic        w_d_elig;
    logic        w_i_elig;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_ack_i;
    logic        w_ack_d;
    logic        w_i_deliver;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant/ack decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_ack_i      = 1'b0;
        w_ack_d      = 1'b0;

        // A requester whose Valid is pulsing this cycle is still holding
        // its request level. Masking it prevents a duplicate grant.
        w_d_elig = D_Req && !D_Valid;
        w_i_elig = I_Req && !I_Valid && !Flush;

        case (r_state)
            IDLE: begin
                if (w_d_elig && w_i_elig) begin
                    if (r_starve == c_starve_limit) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (w_d_elig) begin
                    w_grant_d = 1'b1;
                end else if (w_i_elig) begin
                    w_grant_i = 1'b1;
                end

                if (w_grant_d) begin
                    w_state_next = D_BUSY;
                end else if (w_grant_i) begin
                    w_state_next = I_BUSY;
                end
            end
            I_BUSY: begin
                if (Mem_Ack) begin
                    w_ack_i      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            D_BUSY: begin
                if (Mem_Ack) begin
                    w_ack_d      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Flush in the ack cycle still cancels the fetch.
        w_i_deliver = w_ack_i && !r_drop && !Flush;
    end

    // ------------------------------------------------------------------
    // Memory request, response capture, Drop flag and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Mem_Req   <= 1'b0;
            Mem_Write <= 1'b0;
            Mem_Addr  <= 32'd0;
            Mem_WData <= 32'd0;
            I_Data    <= 32'd0;
            I_Valid   <= 1'b0;
            D_RData   <= 32'd0;
            D_Valid   <= 1'b0;
            r_drop    <= 1'b0;
            r_starve  <= 3'd0;
        end else begin
            I_Valid <= 1'b0;
            D_Valid <= 1'b0;

            // Grants only occur in IDLE and acks only in BUSY, so the
            // branches below are mutually exclusive.
            if (w_grant_d) begin
                Mem_Req   <= 1'b1;
                Mem_Write <= D_Write;
                Mem_Addr  <= D_Addr;
                Mem_WData <= D_WData;
            end else if (w_grant_i) begin
                Mem_Req   <= 1'b1;
                Mem_Write <= 1'b0;
                Mem_Addr  <= I_Addr;
                Mem_WData <= 32'd0;
            end else if (w_ack_i || w_ack_d) begin
                Mem_Req   <= 1'b0;
            end

            if (w_ack_d) begin
                D_Valid <= 1'b1;
                // Stores complete without disturbing the last load data.
                if (!Mem_Write) begin
                    D_RData <= Mem_RData;
                end
            end

            if (w_i_deliver) begin
                I_Valid <= 1'b1;
                I_Data  <= Mem_RData;
            end

            // Drop accumulates Flush while a fetch is outstanding.
            // It clears on the return to IDLE.
            if (r_state == I_BUSY && !Mem_Ack) begin
                r_drop <= r_drop | Flush;
            end else begin
                r_drop <= 1'b0;
            end

            if (w_grant_i) begin
                r_starve <= 3'd0;
            end else if (w_grant_d && I_Req) begin
                if (r_starve != c_starve_limit) begin
                    r_starve <= r_starve + 3'd1;
                end
            end else if (r_state == IDLE && !I_Req) begin
                r_starve <= 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arbiter
// Purpose  : Directed self-checking bench for imem_port_arbiter.
//            Inputs are driven, and outputs sampled, on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_port_arbiter;

    logic        CLK;
    logic        RESET;
    logic        I_Req;
    logic [31:0] I_Addr;
    logic [31:0] I_Data;
    logic        I_Valid;
    logic        D_Req;
    logic        D_Write;
    logic [31:0] D_Addr;
    logic [31:0] D_WData;
    logic [31:0] D_RData;
    logic        D_Valid;
    logic        Flush;
    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;

    int n_checks;
    int n_errors;

    imem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .I_Req     (I_Req),
        .I_Addr    (I_Addr),
        .I_Data    (I_Data),
        .I_Valid   (I_Valid),
        .D_Req     (D_Req),
        .D_Write   (D_Write),
        .D_Addr    (D_Addr),
        .D_WData   (D_WData),
        .D_RData   (D_RData),
        .D_Valid   (D_Valid),
        .Flush     (Flush),
        .Mem_Req   (Mem_Req),
        .Mem_Write (Mem_Write),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_Ack   (Mem_Ack),
        .Mem_RData (Mem_RData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        RESET     = 1'b1;
        I_Req     = 1'b0;
        I_Addr    = 32'd0;
        D_Req     = 1'b0;
        D_Write   = 1'b0;
        D_Addr    = 32'd0;
        D_WData   = 32'd0;
        Flush     = 1'b0;
        Mem_Ack   = 1'b0;
        Mem_RData = 32'd0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_mem_req",   Mem_Req,   0);
        check("rst_mem_write", Mem_Write, 0);
        check("rst_mem_addr",  Mem_Addr,  0);
        check("rst_mem_wdata", Mem_WData, 0);
        check("rst_i_valid",   I_Valid,   0);
        check("rst_i_data",    I_Data,    0);
        check("rst_d_valid",   D_Valid,   0);
        check("rst_d_rdata",   D_RData,   0);
        RESET = 1'b0;
        step();

        // ---------------- single fetch ----------------
        I_Req = 1'b1; I_Addr = 32'hBFC0_0000;
        step();
        check("f1_mem_req",   Mem_Req,   1);
        check("f1_mem_addr",  Mem_Addr,  32'hBFC0_0000);
        check("f1_mem_write", Mem_Write, 0);
        check("f1_mem_wdata", Mem_WData, 0);
        check("f1_i_valid_early", I_Valid, 0);
        step();
        check("f1_req_held", Mem_Req, 1);
        Mem_Ack = 1'b1; Mem_RData = 32'h3C1D_0001;
        step();
        Mem_Ack = 1'b0;
        check("f1_i_valid", I_Valid, 1);
        check("f1_i_data",  I_Data,  32'h3C1D_0001);
        check("f1_req_drop", Mem_Req, 0);
        // I_Req still high during the Valid cycle: must not re-grant.
        step();
        check("f1_no_regrant", Mem_Req, 0);
        check("f1_i_valid_once", I_Valid, 0);
        I_Req = 1'b0;
        step();

        // ---------------- priority: D before I ----------------
        I_Req = 1'b1; I_Addr = 32'hBFC0_0004;
        D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h8000_1000;
        step();
        check("pr_d_first_addr", Mem_Addr, 32'h8000_1000);
        check("pr_d_first_req",  Mem_Req,  1);
        Mem_Ack = 1'b1; Mem_RData = 32'h1111_2222;
        step();
        Mem_Ack = 1'b0;
        check("pr_d_valid", D_Valid, 1);
        check("pr_d_rdata", D_RData, 32'h1111_2222);
        check("pr_i_not_yet", I_Valid, 0);
        D_Req = 1'b0;
        step();
        check("pr_d_valid_once", D_Valid, 0);
        check("pr_i_grant_addr", Mem_Addr, 32'hBFC0_0004);
        check("pr_i_grant_req",  Mem_Req,  1);
        Mem_Ack = 1'b1; Mem_RData = 32'h3333_4444;
        step();
        Mem_Ack = 1'b0;
        check("pr_i_valid", I_Valid, 1);
        check("pr_i_data",  I_Data,  32'h3333_4444);
        check("pr_d_quiet", D_Valid, 0);
        I_Req = 1'b0;
        step();
        check("pr_i_valid_once", I_Valid, 0);
        check("pr_idle", Mem_Req, 0);

        // ---------------- starvation: D,D,D,D,I,D ----------------
        // Flush in each D Valid cycle keeps I out of that one cycle, so
        // both sides compete in the following IDLE cycle.
        I_Req = 1'b1; I_Addr = 32'hBFC0_0008;
        for (int d = 0; d < 4; d++) begin
            D_Req = 1'b1; D_Addr = 32'h8000_2000 + 32'(4 * d);
            Flush = 1'b0;
            step();
            check("st_d_grant_addr", Mem_Addr, 32'h8000_2000 + 32'(4 * d));
            check("st_d_grant_req",  Mem_Req,  1);
            Mem_Ack = 1'b1; Mem_RData = 32'hA000_0000 + 32'(d);
            step();
            Mem_Ack = 1'b0;
            check("st_d_valid", D_Valid, 1);
            check("st_d_rdata", D_RData, 32'hA000_0000 + 32'(d));
            check("st_i_starved", I_Valid, 0);
            Flush = 1'b1;
            step();
            check("st_gap_no_grant", Mem_Req, 0);
        end
        Flush = 1'b0; D_Addr = 32'h8000_2010;
        step();
        check("st_i_forced_addr", Mem_Addr, 32'hBFC0_0008);
        check("st_i_forced_wr",   Mem_Write, 0);
        Mem_Ack = 1'b1; Mem_RData = 32'h5555_6666;
        step();
        Mem_Ack = 1'b0;
        check("st_i_valid", I_Valid, 1);
        check("st_i_data",  I_Data,  32'h5555_6666);
        I_Req = 1'b0;
        step();
        check("st_d_after_i_addr", Mem_Addr, 32'h8000_2010);
        Mem_Ack = 1'b1; Mem_RData = 32'hA000_0004;
        step();
        Mem_Ack = 1'b0;
        check("st_d_after_i_valid", D_Valid, 1);
        D_Req = 1'b0;
        step();

        // ---------------- flush during I_BUSY ----------------
        I_Req = 1'b1; I_Addr = 32'hBFC0_0010;
        step();
        check("fl_grant", Mem_Req, 1);
        Flush = 1'b1; I_Req = 1'b0;
        step();
        Flush = 1'b0;
        check("fl_txn_continues", Mem_Req, 1);
        step();
        check("fl_txn_still", Mem_Req, 1);
        Mem_Ack = 1'b1; Mem_RData = 32'hDDDD_0000;
        step();
        Mem_Ack = 1'b0;
        check("fl_no_valid", I_Valid, 0);
        check("fl_data_kept", I_Data, 32'h5555_6666);
        check("fl_req_drop", Mem_Req, 0);
        I_Req = 1'b1; I_Addr = 32'hBFC0_0100;
        step();
        check("fl_next_addr", Mem_Addr, 32'hBFC0_0100);
        check("fl_next_req",  Mem_Req,  1);
        Mem_Ack = 1'b1; Mem_RData = 32'h7777_8888;
        step();
        Mem_Ack = 1'b0;
        check("fl_next_valid", I_Valid, 1);
        check("fl_next_data",  I_Data,  32'h7777_8888);
        I_Req = 1'b0;
        step();
        // Flush coinciding with Mem_Ack
        I_Req = 1'b1; I_Addr = 32'hBFC0_0200;
        step();
        check("fa_grant", Mem_Req, 1);
        Mem_Ack = 1'b1; Mem_RData = 32'hEEEE_0000; Flush = 1'b1; I_Req = 1'b0;
        step();
        Mem_Ack = 1'b0; Flush = 1'b0;
        check("fa_no_valid",  I_Valid, 0);
        check("fa_data_kept", I_Data, 32'h7777_8888);
        step();

        // ---------------- store (with Flush, which must not affect D) ----
        D_Req = 1'b1; D_Write = 1'b1; D_Addr = 32'h8000_0010; D_WData = 32'hDEAD_BEEF;
        step();
        check("sw_mem_write", Mem_Write, 1);
        check("sw_mem_wdata", Mem_WData, 32'hDEAD_BEEF);
        check("sw_mem_addr",  Mem_Addr,  32'h8000_0010);
        Mem_Ack = 1'b1; Mem_RData = 32'h1234_5678; Flush = 1'b1;
        step();
        Mem_Ack = 1'b0; Flush = 1'b0;
        check("sw_d_valid", D_Valid, 1);
        check("sw_rdata_kept", D_RData, 32'hA000_0004);
        D_Req = 1'b0; D_Write = 1'b0;
        step();

        // ---------------- reset during D_BUSY ----------------
        D_Req = 1'b1; D_Addr = 32'h8000_3000;
        step();
        check("rs_grant", Mem_Req, 1);
        RESET = 1'b1;
        #1;
        check("rs_async_drop", Mem_Req, 0);
        D_Req = 1'b0;
        step();
        RESET = 1'b0;
        Mem_Ack = 1'b1; Mem_RData = 32'h9999_9999;
        step();
        Mem_Ack = 1'b0;
        check("rs_no_d_valid", D_Valid, 0);
        check("rs_stray_ack_req", Mem_Req, 0);
        check("rs_rdata_cleared", D_RData, 0);
        D_Req = 1'b1; D_Addr = 32'h8000_3004;
        step();
        check("rs_regrant_addr", Mem_Addr, 32'h8000_3004);
        check("rs_regrant_req",  Mem_Req,  1);
        Mem_Ack = 1'b1; Mem_RData = 32'h4242_4242;
        step();
        Mem_Ack = 1'b0;
        check("rs_regrant_valid", D_Valid, 1);
        check("rs_regrant_data",  D_RData, 32'h4242_4242);
        D_Req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single backing memory port between the instruction-fetch stage (I-side) and the memory stage (D-side). It runs a req/ack handshake of variable latency toward memory and returns data to the winning requester with a one-cycle Valid pulse. It applies D-over-I priority, bounded by a starvation guard so fetch always makes progress. A Flush input cancels fetch responses on branch redirect. Sits between IF/MEM and the memory model.

## Interface
- STARVE_LIMIT, 4: consecutive D grants allowed while I_Req is pending before I is forced; range 1..7.
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- I_Req  in  1  fetch request, level; held with I_Addr stable until I_Valid
- I_Addr  in  32  fetch address
- I_Data  out  32  fetched word, valid when I_Valid
- I_Valid  out  1  one-cycle pulse, fetch complete
- D_Req  in  1  data request, level; held with D_Write/D_Addr/D_WData stable until D_Valid
- D_Write  in  1  1 = store, 0 = load
- D_Addr  in  32  data address
- D_WData  in  32  store data
- D_RData  out  32  load data, valid when D_Valid
- D_Valid  out  1  one-cycle pulse, data access complete (loads and stores)
- Flush  in  1  fetch redirect; cancels any fetch in flight
- Mem_Req  out  1  memory request, held until Mem_Ack
- Mem_Write  out  1  registered copy of D_Write for D grants, 0 for I grants
- Mem_Addr  out  32  registered request address
- Mem_WData  out  32  registered store data
- Mem_Ack  in  1  one-cycle completion from memory
- Mem_RData  in  32  read data, valid with Mem_Ack

## Operation
- States: IDLE, I_BUSY, D_BUSY. 1-bit flag Drop. 3-bit counter Starve.
- Transitions out of IDLE:
  - Only D eligible: go to D_BUSY.
  - Only I eligible: go to I_BUSY.
  - Both eligible and Starve == STARVE_LIMIT: go to I_BUSY.
  - Both eligible otherwise: go to D_BUSY.
- Eligibility:
  - D eligible = D_Req && !D_Valid.
  - I eligible = I_Req && !I_Valid && !Flush.
- Entering a BUSY state registers Mem_Addr, Mem_Write and Mem_WData. Mem_WData is 0 for an I grant. Mem_Req is set to 1.
- In a BUSY state, Mem_Req stays 1 until Mem_Ack. On the Mem_Ack edge:
  - Mem_Req goes to 0 and the state returns to IDLE.
  - Mem_RData is captured into I_Data or D_RData.
  - The matching Valid is set for exactly one cycle.
- Mem_Ack is ignored in IDLE, including stray or post-reset acks.
- Drop is set by Flush in I_BUSY, including Flush in the same cycle as Mem_Ack.
  - While Drop is set, the memory transaction still completes.
  - I_Data is not updated and I_Valid stays 0.
  - Drop clears on return to IDLE.
- Flush during D_BUSY or IDLE does not affect D.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each D grant while I_Req is 1.
  - Clears on an I grant, or in any IDLE cycle with I_Req 0.
- Store completion: D_Valid pulses and D_RData holds its previous value.

## Timing
- Reset values: state IDLE, Drop 0, Starve 0, all outputs 0 (including I_Data, D_RData, Mem_Addr, Mem_WData). An abort mid-transaction drops Mem_Req asynchronously.
- Grant: request seen in IDLE at cycle T gives Mem_Req = 1 at T+1.
- Completion: Mem_Ack sampled at cycle T+k (k ≥ 1) gives Valid = 1 and data at T+k+1. In that same cycle the state is IDLE and can grant again.
  - Minimum request-to-Valid latency is 2 cycles.
  - Minimum spacing between grants is 2 cycles.
- Both requesters pending (alternating or starvation-driven): back-to-back transactions occupy 1 + k cycles each.
- Simultaneous Flush and I_Req in IDLE: no I grant that cycle. D may still be granted.
- RESET asserted during BUSY: Mem_Req = 0 immediately. No Valid is produced. Requesters must re-issue.

## Test plan
- Single fetch: I_Req, I_Addr = 0xBFC00000, memory acks 1 cycle after Mem_Req with 0x3C1D0001 -> Mem_Addr = 0xBFC00000 and Mem_Write = 0 at T+1; I_Valid one cycle at T+3 with I_Data = 0x3C1D0001; no second grant in the Valid cycle.
- Priority: I_Req and D_Req rise together, D load at 0x80001000 -> D served first, D_Valid pulses; then I served; each Valid appears exactly once.
- Starvation, STARVE_LIMIT = 4: D_Req held continuously (re-asserted with new addresses) and I_Req held -> grant order D,D,D,D,I,D...; I_Valid appears after the 4th D_Valid.
- Flush: Flush during I_BUSY, ack after 3 cycles -> Mem transaction completes, I_Valid stays 0, I_Data unchanged. Next I_Req with I_Addr = 0xBFC00100 is then granted normally.
- Store: D_Write = 1, D_Addr = 0x80000010, D_WData = 0xDEADBEEF -> Mem_Write = 1, Mem_WData = 0xDEADBEEF; D_Valid pulse; D_RData unchanged.
- Reset mid-operation: RESET asserted in D_BUSY, then Mem_Ack arrives after reset release -> Mem_Req 0 immediately, no D_Valid, state IDLE, stray ack ignored.
